// File: rtl/count_sequencer.sv
// Purpose : shares one W-bit load/count datapath among NREQ requesters. Each run
//           is "load START, count up to TARGET". Requesters are served round-robin.
//           Each run ends with a done pulse, or with an abort or a timeout.
// Latency : from request sampled in IDLE to done is 3 + ((target - start) mod 2^W) cycles.
// Backpres: req is a level; a requester stays pending until it is granted.
//           Operands are latched at grant and held for the whole run.
// Ports   : clk/rst (sync, active-low) ; req, req_start, req_target, abort (requester side)
//           gnt, done, err, busy (status) ; ctr_load, ctr_load_val, ctr_en, ctr_value (datapath)
module count_sequencer #(
  parameter int W       = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_start,
  input  logic [NREQ*W-1:0] req_target,
  input  logic              abort,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              ctr_load,
  output logic [W-1:0]      ctr_load_val,
  output logic              ctr_en,
  input  logic [W-1:0]      ctr_value
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  // ptr_q holds the index with highest priority on the next arbitration.
  // The value is (last winner + 1) mod NREQ, and it resets to 0 so that
  // requester 0 wins first.
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [W-1:0]      start_q, start_d;
  logic [W-1:0]      target_q, target_d;
  logic [CW-1:0]     run_cnt_q, run_cnt_d;
  logic              err_q, err_d;

  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     ptr_next;
  logic              timeout_hit;
  int                idx;

  // Round-robin search starting at ptr_q.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  assign ptr_next    = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
  // The run counter starts at 0 on the first RUN cycle. Hitting TIMEOUT-1 therefore
  // means this is the TIMEOUT-th RUN cycle.
  assign timeout_hit = (run_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    start_d   = start_q;
    target_d  = target_q;
    run_cnt_d = '0;
    err_d     = 1'b0;
    ctr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d         = LOAD;
          gnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          gidx_d          = win_idx;
          start_d         = req_start[int'(win_idx)*W +: W];
          target_d        = req_target[int'(win_idx)*W +: W];
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // abort wins over a match, and a match wins over a timeout.
        ctr_en    = !abort && (ctr_value != target_q);
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end else if (ctr_value == target_q) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_next;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      start_q   <= '0;
      target_q  <= '0;
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      start_q   <= start_d;
      target_q  <= target_d;
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = (state_q == DONE) ? gnt_q : '0;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);
  assign ctr_load     = (state_q == LOAD);
  assign ctr_load_val = start_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural counter on the datapath side.
module tb_count_sequencer;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_start, req_target;
  logic        abort;
  logic [1:0]  gnt, done;
  logic        err, busy, ctr_load, ctr_en;
  logic [7:0]  ctr_load_val, ctr_value;

  logic [7:0]  cnt_q;
  logic        tie;

  int n_cmp = 0;
  int n_fail = 0;

  // results of do_run
  int          run_steps, run_en, run_nvals;
  logic [1:0]  run_gnt, run_done;
  logic        run_load;
  logic [7:0]  run_load_val;
  logic [7:0]  run_vals [8];

  count_sequencer #(.W(8), .NREQ(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_start(req_start), .req_target(req_target),
    .abort(abort), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .ctr_load(ctr_load), .ctr_load_val(ctr_load_val), .ctr_en(ctr_en), .ctr_value(ctr_value)
  );

  always #5 clk = ~clk;

  // Counter datapath; tie freezes counting to provoke a timeout.
  always @(posedge clk) begin
    if (!rst)          cnt_q <= 8'h00;
    else if (ctr_load) cnt_q <= ctr_load_val;
    else if (ctr_en && !tie) cnt_q <= cnt_q + 8'd1;
  end
  assign ctr_value = cnt_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] s, input logic [7:0] t);
    req_start[i*8 +: 8]  = s;
    req_target[i*8 +: 8] = t;
  endtask

  // Issues one request and measures the run; all comparisons are done by the caller.
  task automatic do_run(input logic [1:0] mask);
    run_en = 0; run_nvals = 0;
    for (int i = 0; i < 8; i++) run_vals[i] = 8'h00;
    req = mask;
    step();
    run_steps = 1;
    run_gnt = gnt; run_load = ctr_load; run_load_val = ctr_load_val;
    req = 2'b00;
    while (done == 2'b00 && run_steps < 400) begin
      if (busy && !ctr_load) begin
        if (run_nvals < 8) run_vals[run_nvals] = ctr_value;
        run_nvals++;
        if (ctr_en) run_en++;
      end
      step();
      run_steps++;
    end
    run_done = done;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 2'b11; abort = 1'b0; tie = 1'b0;
    req_start = '0; req_target = '0;
    step(); step();
    n_cmp++; if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status gnt=%b busy=%b done=%b err=%b, required 00/0/00/0", gnt, busy, done, err); end
    n_cmp++; if (ctr_load !== 1'b0 || ctr_en !== 1'b0 || ctr_load_val !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctr load=%b en=%b val=%h, required 0/0/00", ctr_load, ctr_en, ctr_load_val); end
    rst = 1'b1;
    step();
    n_cmp++; if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_gnt gnt=%b, required 01", gnt); end
    req = 2'b00;
    step(); step();
    n_cmp++; if (done !== 2'b01) begin
      n_fail++; $display("FAIL reset_run_done done=%b, required 01", done); end
    step();
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00) begin
      n_fail++; $display("FAIL reset_back_idle busy=%b gnt=%b, required 0/00", busy, gnt); end
  endtask

  task automatic test_single();
    set_ops(0, 8'h10, 8'h14);
    do_run(2'b01);
    n_cmp++; if (run_load !== 1'b1 || run_load_val !== 8'h10 || run_gnt !== 2'b01) begin
      n_fail++; $display("FAIL single_load load=%b val=%h gnt=%b, required 1/10/01", run_load, run_load_val, run_gnt); end
    n_cmp++; if (run_en !== 4) begin
      n_fail++; $display("FAIL single_en_cycles got %0d, required 4", run_en); end
    n_cmp++; if (run_steps !== 7 || run_done !== 2'b01) begin
      n_fail++; $display("FAIL single_latency steps=%0d done=%b, required 7/01", run_steps, run_done); end
  endtask

  task automatic test_wrap();
    set_ops(1, 8'hFE, 8'h01);
    do_run(2'b10);
    n_cmp++; if (run_nvals !== 4 || run_vals[0] !== 8'hFE || run_vals[1] !== 8'hFF ||
                 run_vals[2] !== 8'h00 || run_vals[3] !== 8'h01) begin
      n_fail++; $display("FAIL wrap_seq n=%0d %h %h %h %h, required 4 FE FF 00 01",
                         run_nvals, run_vals[0], run_vals[1], run_vals[2], run_vals[3]); end
    n_cmp++; if (run_steps !== 6 || run_done !== 2'b10) begin
      n_fail++; $display("FAIL wrap_latency steps=%0d done=%b, required 6/10", run_steps, run_done); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g_seen [3];
    int nl;
    nl = 0;
    for (int i = 0; i < 3; i++) g_seen[i] = 2'b00;
    set_ops(0, 8'h33, 8'h33); set_ops(1, 8'h33, 8'h33);
    req = 2'b11;
    for (int c = 0; c < 40 && nl < 3; c++) begin
      step();
      if (ctr_load) begin g_seen[nl] = gnt; nl++; end
    end
    req = 2'b00;
    for (int c = 0; c < 20 && busy; c++) step();
    n_cmp++; if (nl !== 3 || g_seen[0] !== 2'b01 || g_seen[1] !== 2'b10 || g_seen[2] !== 2'b01) begin
      n_fail++; $display("FAIL rr_alternate n=%0d %b %b %b, required 3 01 10 01", nl, g_seen[0], g_seen[1], g_seen[2]); end
    set_ops(1, 8'h20, 8'h20);
    do_run(2'b10);
    n_cmp++; if (run_gnt !== 2'b10) begin
      n_fail++; $display("FAIL rr_single_a gnt=%b, required 10", run_gnt); end
    // The pointer now favours requester 0, but only requester 1 asks.
    do_run(2'b10);
    n_cmp++; if (run_gnt !== 2'b10 || run_done !== 2'b10) begin
      n_fail++; $display("FAIL rr_single_b gnt=%b done=%b, required 10/10", run_gnt, run_done); end
  endtask

  task automatic test_equal();
    set_ops(0, 8'h55, 8'h55);
    do_run(2'b01);
    n_cmp++; if (run_nvals !== 1 || run_vals[0] !== 8'h55 || run_en !== 0) begin
      n_fail++; $display("FAIL equal_run n=%0d val=%h en=%0d, required 1/55/0", run_nvals, run_vals[0], run_en); end
    n_cmp++; if (run_steps !== 3 || run_done !== 2'b01) begin
      n_fail++; $display("FAIL equal_latency steps=%0d done=%b, required 3/01", run_steps, run_done); end
  endtask

  task automatic test_abort();
    logic [1:0] seen;
    set_ops(1, 8'h00, 8'h80);
    req = 2'b10;
    step();
    n_cmp++; if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL abort_gnt gnt=%b, required 10", gnt); end
    req = 2'b00;
    step(); step(); step();
    n_cmp++; if (ctr_en !== 1'b1 || ctr_value !== 8'h02) begin
      n_fail++; $display("FAIL abort_pre en=%b val=%h, required 1/02", ctr_en, ctr_value); end
    abort = 1'b1;
    #1;
    n_cmp++; if (ctr_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_en_same_cycle en=%b, required 0", ctr_en); end
    step();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin
      n_fail++; $display("FAIL abort_idle busy=%b gnt=%b done=%b, required 0/00/00", busy, gnt, done); end
    seen = 2'b00;
    for (int c = 0; c < 3; c++) begin step(); seen = seen | done; end
    n_cmp++; if (seen !== 2'b00) begin
      n_fail++; $display("FAIL abort_no_done done=%b, required 00", seen); end
    // Pointer moved past requester 1, so requester 0 wins a tie.
    set_ops(0, 8'h44, 8'h44); set_ops(1, 8'h44, 8'h44);
    do_run(2'b11);
    n_cmp++; if (run_gnt !== 2'b01) begin
      n_fail++; $display("FAIL abort_ptr_adv gnt=%b, required 01", run_gnt); end
  endtask

  task automatic test_reset_midrun();
    logic seen;
    set_ops(1, 8'h00, 8'h80);
    req = 2'b10;
    step();
    req = 2'b00;
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00 || err !== 1'b0 || ctr_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state busy=%b gnt=%b done=%b err=%b en=%b, required all 0", busy, gnt, done, err, ctr_en); end
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin step(); seen = seen | (|done) | err; end
    n_cmp++; if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_quiet saw done/err=%b, required 0", seen); end
    set_ops(1, 8'h44, 8'h44);
    do_run(2'b11);
    n_cmp++; if (run_gnt !== 2'b01) begin
      n_fail++; $display("FAIL midrst_ptr_reset gnt=%b, required 01", run_gnt); end
  endtask

  task automatic test_timeout();
    int steps;
    logic [1:0] seen;
    tie = 1'b1;
    set_ops(0, 8'h00, 8'h05);
    req = 2'b01;
    steps = 0; seen = 2'b00;
    while (err !== 1'b1 && steps < 1000) begin
      step();
      steps++;
      seen = seen | done;
      if (ctr_load) req = 2'b00;
    end
    n_cmp++; if (steps !== TMO + 2) begin
      n_fail++; $display("FAIL timeout_latency steps=%0d, required %0d", steps, TMO + 2); end
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00 || seen !== 2'b00) begin
      n_fail++; $display("FAIL timeout_state busy=%b gnt=%b done_seen=%b, required 0/00/00", busy, gnt, seen); end
    step();
    n_cmp++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse err=%b, required 0", err); end
    tie = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_equal();
    test_abort();
    test_reset_midrun();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
